// File: rtl/maze_multi_move_ctrl_if.sv
// maze_multi_move_ctrl_if: obstacle-lookup and pixel-plot req/ack handshakes
interface maze_multi_move_ctrl_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           obs_req;
    logic [X_W-1:0] obs_x;
    logic [Y_W-1:0] obs_y;
    logic           obs_valid;
    logic           obs_block;
    logic           draw_req;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_erase;
    logic [1:0]     draw_player;
    logic           draw_done;

    modport master (
        output obs_req, obs_x, obs_y, draw_req, draw_x, draw_y, draw_erase, draw_player,
        input  obs_valid, obs_block, draw_done
    );

    modport slave (
        input  obs_req, obs_x, obs_y, draw_req, draw_x, draw_y, draw_erase, draw_player,
        output obs_valid, obs_block, draw_done
    );
endinterface

// File: rtl/maze_multi_move_ctrl.sv
// maze_multi_move_ctrl: tick-driven movement of up to four sprites with obstacle lookup, plotting and win detection
module maze_multi_move_ctrl #(
    parameter int N_PLAYERS   = 2,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int GOAL_X      = 158,
    parameter int GOAL_Y      = 118,
    parameter int TICK_CYCLES = 833333
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3*N_PLAYERS-1:0]    move,
    maze_multi_move_ctrl_if.master    bus,
    output logic [N_PLAYERS*X_W-1:0]  pos_x,
    output logic [N_PLAYERS*Y_W-1:0]  pos_y,
    output logic                      win,
    output logic [1:0]                win_player,
    output logic [3:0]                state_cur
);
    localparam int CW = $clog2(TICK_CYCLES);

    typedef enum logic [3:0] {WAIT_TICK, ERASE, SAMPLE, OBS_Q, COMMIT, DRAW, CHECK, WIN} state_t;

    state_t         st_q, st_d;
    logic [CW-1:0]  cnt_q;
    logic           pend_q, wrap, ok, at_goal, win_q, win_d, dreq;
    logic [1:0]     p_q, p_d, wp_q, wp_d;
    logic [X_W-1:0] px_q [4];
    logic [Y_W-1:0] py_q [4];
    logic [X_W-1:0] cx, tx_q, tx_d;
    logic [Y_W-1:0] cy, ty_q, ty_d;
    logic [2:0]     mv [4];
    logic [2:0]     m;

    for (genvar i = 0; i < 4; i++) begin : g_pl
        if (i < N_PLAYERS) begin : g_on
            assign mv[i] = move[3*i +: 3];
            assign pos_x[i*X_W +: X_W] = px_q[i];
            assign pos_y[i*Y_W +: Y_W] = py_q[i];
        end else begin : g_off
            assign mv[i] = 3'd0;
        end
    end

    assign cx      = px_q[p_q];
    assign cy      = py_q[p_q];
    assign m       = mv[p_q];
    assign wrap    = cnt_q == CW'(TICK_CYCLES - 1);
    assign at_goal = cx == X_W'(GOAL_X) && cy == Y_W'(GOAL_Y);
    assign ok      = (m == 3'd1 && cx != '0) || (m == 3'd2 && cx != X_W'(X_MAX)) ||
                     (m == 3'd3 && cy != '0) || (m == 3'd4 && cy != Y_W'(Y_MAX));
    assign tx_d    = m == 3'd1 ? cx - 1'b1 : m == 3'd2 ? cx + 1'b1 : cx;
    assign ty_d    = m == 3'd3 ? cy - 1'b1 : m == 3'd4 ? cy + 1'b1 : cy;

    // Free-running tick counter; any wraps during a frame collapse into one pending tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
            pend_q <= wrap | (pend_q & (st_q != WAIT_TICK));
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st_q <= WAIT_TICK;
        else       st_q <= st_d;
    end

    // Next state; player index and win flag advance only out of CHECK
    always_comb begin
        st_d  = st_q;
        p_d   = p_q;
        win_d = win_q;
        wp_d  = wp_q;
        case (st_q)
            WAIT_TICK: st_d = pend_q ? ERASE : WAIT_TICK;
            ERASE:     st_d = bus.draw_done ? SAMPLE : ERASE;
            SAMPLE:    st_d = ok ? OBS_Q : DRAW;
            OBS_Q:     st_d = !bus.obs_valid ? OBS_Q : bus.obs_block ? DRAW : COMMIT;
            COMMIT:    st_d = DRAW;
            DRAW:      st_d = bus.draw_done ? CHECK : DRAW;
            CHECK: begin
                if (at_goal) begin
                    win_d = 1'b1;
                    wp_d  = p_q;
                    st_d  = WIN;
                end else if (p_q == 2'(N_PLAYERS - 1)) begin
                    p_d  = '0;
                    st_d = WAIT_TICK;
                end else begin
                    p_d  = p_q + 1'b1;
                    st_d = ERASE;
                end
            end
            WIN:       st_d = WIN;
            default:   st_d = WAIT_TICK;
        endcase
    end

    // Player index, win flag, target cell captured in SAMPLE, positions updated in COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= '0;
            win_q <= 1'b0;
            wp_q  <= '0;
            tx_q  <= '0;
            ty_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                px_q[i] <= X_W'(START_X + i);
                py_q[i] <= Y_W'(START_Y);
            end
        end else begin
            p_q   <= p_d;
            win_q <= win_d;
            wp_q  <= wp_d;
            if (st_q == SAMPLE) begin
                tx_q <= tx_d;
                ty_q <= ty_d;
            end
            if (st_q == COMMIT) begin
                px_q[p_q] <= tx_q;
                py_q[p_q] <= ty_q;
            end
        end
    end

    assign dreq            = st_q == ERASE || st_q == DRAW;
    assign bus.obs_req     = st_q == OBS_Q;
    assign bus.obs_x       = tx_q;
    assign bus.obs_y       = ty_q;
    assign bus.draw_req    = dreq;
    assign bus.draw_x      = cx;
    assign bus.draw_y      = cy;
    assign bus.draw_erase  = st_q == ERASE;
    assign bus.draw_player = dreq ? p_q : 2'd0;
    assign win             = win_q;
    assign win_player      = wp_q;
    assign state_cur       = st_q;
endmodule

// File: tb/tb_maze_multi_move_ctrl.sv
// tb_maze_multi_move_ctrl: table-driven, directed and randomized checks against a frame-level reference model
module tb_maze_multi_move_ctrl;
    localparam int XM = 7, YM = 7, SX = 1, SY = 1, GX = 3, GY = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  move = '0;
    logic [15:0] pos_x;
    logic [13:0] pos_y;
    logic        win;
    logic [1:0]  win_player;
    logic [3:0]  state_cur;

    maze_multi_move_ctrl_if #(.X_W(8), .Y_W(7)) dif();

    maze_multi_move_ctrl #(
        .N_PLAYERS(2), .X_W(8), .Y_W(7), .X_MAX(XM), .Y_MAX(YM),
        .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY), .TICK_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .move(move), .bus(dif),
        .pos_x(pos_x), .pos_y(pos_y), .win(win), .win_player(win_player), .state_cur(state_cur)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int pl; int x; int y;} txn_t;
    typedef struct {int m0; int m1; bit b0; bit b1; int x0; int y0; int x1; int y1; bit w; int wp;} vec_t;

    txn_t exp_q[$];
    txn_t got_q[$];
    int   checks = 0, errors = 0;
    int   mpx[2], mpy[2], mwp, mv[2];
    bit   mwin, blk[2];
    int   od = 0, dd = 0, cur_p = 0, last_hold = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mpx[0] = SX; mpx[1] = SX + 1; mpy[0] = SY; mpy[1] = SY;
        mwin = 1'b0; mwp = 0;
    endtask

    // One frame of the rules: erase, optional lookup, optional move, redraw, win test, players in order
    task automatic model_frame();
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            int tx, ty;
            exp_q.push_back('{0, p, mpx[p], mpy[p]});
            tx = mpx[p] + int'(mv[p] == 2) - int'(mv[p] == 1);
            ty = mpy[p] + int'(mv[p] == 4) - int'(mv[p] == 3);
            if (mv[p] >= 1 && mv[p] <= 4 && tx >= 0 && tx <= XM && ty >= 0 && ty <= YM) begin
                exp_q.push_back('{1, p, tx, ty});
                if (!blk[p]) begin mpx[p] = tx; mpy[p] = ty; end
            end
            exp_q.push_back('{2, p, mpx[p], mpy[p]});
            if (mpx[p] == GX && mpy[p] == GY) begin mwin = 1'b1; mwp = p; break; end
        end
    endtask

    task automatic step();
        logic po, pd;
        @(negedge clk);
        po = dif.obs_valid;
        pd = dif.draw_done;
        dif.obs_valid = 1'b0;
        dif.draw_done = 1'b0;
        dif.obs_block = 1'($urandom);
        if (po) cmp("obs_req_drop", 32'(dif.obs_req), 0);
        if (pd) cmp("draw_req_drop", 32'(dif.draw_req), 0);
    endtask

    task automatic idle(input int k, output int reqs);
        reqs = 0;
        repeat (k) begin
            step();
            if (dif.obs_req || dif.draw_req) reqs++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        dif.obs_valid = 1'b0;
        dif.draw_done = 1'b0;
        move = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Acknowledge requests after od/dd wait cycles and log each accepted transaction
    task automatic serve(input int n);
        int wo = 0, wd = 0, cyc = 0, fx = 0, fy = 0, gx = 0, gy = 0;
        got_q.delete();
        while (got_q.size() < n && cyc < 400) begin
            step();
            cyc++;
            if (dif.draw_req) begin
                if (wd == 0) begin gx = int'(dif.draw_x); gy = int'(dif.draw_y); end
                if (wd == dd) begin
                    if (dd > 0) cmp("draw_coords_stable", int'(dif.draw_x) * 256 + int'(dif.draw_y), gx * 256 + gy);
                    if (dif.draw_erase) cur_p = int'(dif.draw_player);
                    got_q.push_back('{dif.draw_erase ? 0 : 2, int'(dif.draw_player), int'(dif.draw_x), int'(dif.draw_y)});
                    dif.draw_done = 1'b1;
                    wd = 0;
                end else wd++;
            end
            if (dif.obs_req) begin
                if (wo == 0) begin fx = int'(dif.obs_x); fy = int'(dif.obs_y); end
                if (wo == od) begin
                    if (od > 0) cmp("obs_coords_stable", int'(dif.obs_x) * 256 + int'(dif.obs_y), fx * 256 + fy);
                    got_q.push_back('{1, cur_p, int'(dif.obs_x), int'(dif.obs_y)});
                    dif.obs_valid = 1'b1;
                    dif.obs_block = blk[cur_p];
                    last_hold = wo + 1;
                    wo = 0;
                end else wo++;
            end
        end
        if (got_q.size() < n) cmp("serve_timeout", got_q.size(), n);
    endtask

    task automatic frame(input string tag, input int m0, input int m1, input bit b0, input bit b1);
        int r;
        mv[0] = m0; mv[1] = m1; blk[0] = b0; blk[1] = b1;
        move = {3'(m1), 3'(m0)};
        model_frame();
        serve(exp_q.size());
        idle(2, r);
        cmp({tag, "_txn_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].kind != exp_q[i].kind || got_q[i].pl != exp_q[i].pl ||
                got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y) begin
                errors++;
                $display("FAIL %s_txn%0d: got kind=%0d p=%0d (%0d,%0d) expected kind=%0d p=%0d (%0d,%0d)",
                         tag, i, got_q[i].kind, got_q[i].pl, got_q[i].x, got_q[i].y,
                         exp_q[i].kind, exp_q[i].pl, exp_q[i].x, exp_q[i].y);
            end
        end
        cmp({tag, "_p0x"}, 32'(pos_x[7:0]), mpx[0]);
        cmp({tag, "_p0y"}, 32'(pos_y[6:0]), mpy[0]);
        cmp({tag, "_p1x"}, 32'(pos_x[15:8]), mpx[1]);
        cmp({tag, "_p1y"}, 32'(pos_y[13:7]), mpy[1]);
        cmp({tag, "_win"}, 32'(win), 32'(mwin));
        cmp({tag, "_win_player"}, 32'(win_player), mwin ? mwp : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   n, r;
        tbl[0] = '{2, 0, 0, 0, 2, 1, 2, 1, 0, 0};
        tbl[1] = '{4, 4, 1, 0, 2, 1, 2, 2, 0, 0};
        tbl[2] = '{1, 7, 0, 0, 1, 1, 2, 2, 0, 0};
        tbl[3] = '{1, 3, 0, 1, 0, 1, 2, 2, 0, 0};
        tbl[4] = '{1, 7, 0, 0, 0, 1, 2, 2, 0, 0};
        tbl[5] = '{3, 2, 0, 0, 0, 0, 3, 2, 0, 0};
        tbl[6] = '{3, 3, 0, 0, 0, 0, 3, 1, 1, 1};
        dif.obs_valid = 1'b0;
        dif.draw_done = 1'b0;
        dif.obs_block = 1'b0;

        do_reset();
        cmp("rst_p0x", 32'(pos_x[7:0]), 1);
        cmp("rst_p0y", 32'(pos_y[6:0]), 1);
        cmp("rst_p1x", 32'(pos_x[15:8]), 2);
        cmp("rst_p1y", 32'(pos_y[13:7]), 1);
        cmp("rst_obs_req", 32'(dif.obs_req), 0);
        cmp("rst_draw_req", 32'(dif.draw_req), 0);
        cmp("rst_draw_erase", 32'(dif.draw_erase), 0);
        cmp("rst_draw_player", 32'(dif.draw_player), 0);
        cmp("rst_win", 32'(win), 0);
        cmp("rst_win_player", 32'(win_player), 0);
        step();
        dif.draw_done = 1'b1;
        dif.obs_valid = 1'b1;
        dif.obs_block = 1'b0;
        n = 0;
        while (!dif.draw_req && n < 10) begin step(); n++; end
        cmp("first_erase_seen", 32'(dif.draw_req), 1);
        cmp("first_erase_latency_ok", 32'(n <= 5), 1);
        cmp("first_erase_flag", 32'(dif.draw_erase), 1);
        cmp("first_erase_x", 32'(dif.draw_x), 1);
        cmp("first_erase_y", 32'(dif.draw_y), 1);
        cmp("stray_ack_p0x", 32'(pos_x[7:0]), 1);

        for (int i = 0; i < 7; i++) begin
            frame($sformatf("tbl%0d", i), tbl[i].m0, tbl[i].m1, tbl[i].b0, tbl[i].b1);
            cmp($sformatf("tbl%0d_x0", i), 32'(pos_x[7:0]), tbl[i].x0);
            cmp($sformatf("tbl%0d_y0", i), 32'(pos_y[6:0]), tbl[i].y0);
            cmp($sformatf("tbl%0d_x1", i), 32'(pos_x[15:8]), tbl[i].x1);
            cmp($sformatf("tbl%0d_y1", i), 32'(pos_y[13:7]), tbl[i].y1);
            cmp($sformatf("tbl%0d_w", i), 32'(win), 32'(tbl[i].w));
            cmp($sformatf("tbl%0d_wp", i), 32'(win_player), tbl[i].wp);
        end
        idle(12, r);
        cmp("tbl_win_quiet", r, 0);
        cmp("tbl_win_frozen_x1", 32'(pos_x[15:8]), 3);

        do_reset();
        od = 5;
        frame("obs_wait", 3, 0, 1'b1, 1'b0);
        cmp("obs_hold_cycles", last_hold, 6);
        od = 0;

        do_reset();
        frame("win_a", 2, 0, 1'b0, 1'b0);
        frame("win_b", 2, 0, 1'b0, 1'b0);
        cmp("win_p0_flag", 32'(win), 1);
        cmp("win_p0_player", 32'(win_player), 0);
        idle(12, r);
        cmp("win_p0_quiet", r, 0);
        cmp("win_p0_sticky", 32'(win), 1);

        do_reset();
        for (int i = 0; i < 7; i++) frame("bnd_down", 4, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) frame("bnd_right", 2, 0, 1'b0, 1'b0);
        cmp("bnd_corner_x", 32'(pos_x[7:0]), 7);
        cmp("bnd_corner_y", 32'(pos_y[6:0]), 7);

        do_reset();
        frame("rst_a", 2, 0, 1'b0, 1'b0);
        move = '0;
        n = 0;
        while (!dif.draw_req && n < 20) begin step(); n++; end
        cmp("rst_mid_req_seen", 32'(dif.draw_req), 1);
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        cmp("async_drop_draw_req", 32'(dif.draw_req), 0);
        cmp("async_drop_obs_req", 32'(dif.obs_req), 0);
        cmp("async_p0x", 32'(pos_x[7:0]), 1);
        cmp("async_p0y", 32'(pos_y[6:0]), 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        frame("post_rst", 2, 4, 1'b0, 1'b0);

        do_reset();
        for (int k = 0; k < 40; k++) begin
            od = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            frame("rnd", $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom));
            if (mwin) begin
                idle(10, r);
                cmp("rnd_win_quiet", r, 0);
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
